fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: WORD_SIZE, 32, width of PC and instruction words.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-005 Port: stall  input  1  downstream decoder cannot accept; hold fetch outputs.
REQ-006 Port: redirect_en  input  1  taken branch/jump from execute; squash and reload PC.
REQ-007 Port: redirect_pc  input  WORD_SIZE  branch/jump target.
REQ-008 Port: halt  input  1  stop fetching after this cycle.
REQ-009 Port: imem_addr  output  WORD_SIZE  byte address to instruction memory; equals current PC.
REQ-010 Port: imem_rdata  input  WORD_SIZE  instruction word; combinational read of imem_addr, valid same cycle.
REQ-011 Port: instruction  output  WORD_SIZE  registered instruction presented to the decoder.
REQ-012 Port: inst_valid  output  1  instruction is a real fetched instruction.
REQ-013 Port: pc_out  output  WORD_SIZE  PC of instruction.
REQ-014 Port: pc_plus4  output  WORD_SIZE  pc_out + 4, for link/branch-offset use downstream.
REQ-015 Port: halted  output  1  high while in HALTED state.
REQ-016 Port: fetch_count  output  16  number of instructions captured since reset.

Function
REQ-017 States SHALL be BOOT, RUN, HALTED, encoded in a registered state variable.
REQ-018 BOOT SHALL last exactly one cycle after reset release, capture nothing, leave PC unchanged, then go to RUN.
REQ-019 In RUN with stall=0, redirect_en=0: instruction<=imem_rdata, pc_out<=PC, pc_plus4<=PC+4, inst_valid<=1, PC<=PC+4, fetch_count increments.
REQ-020 In RUN with stall=1, redirect_en=0: PC, instruction, pc_out, pc_plus4, inst_valid, fetch_count all hold.
REQ-021 redirect_en=1 in any state SHALL take priority over stall and halt: PC<={redirect_pc[31:2],2'b00}, inst_valid<=0, instruction<=0, next state RUN.
REQ-022 Fetch latency SHALL be one cycle: word at imem_addr in cycle N appears on instruction in cycle N+1.
REQ-023 halt=1 in RUN (no redirect) SHALL complete that cycle's capture per REQ-019/020, then enter HALTED.
REQ-024 In HALTED: inst_valid<=0, PC frozen, fetch_count frozen, halted=1; exit only via redirect_en or reset.
REQ-025 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-026 fetch_count SHALL saturate at 16'hFFFF.
REQ-027 imem_addr SHALL be driven from the PC register only (no combinational path from redirect_pc).

Reset
REQ-028 On clk edge with reset_n=0: PC=RESET_PC, state=BOOT, instruction=0, inst_valid=0, pc_out=0, pc_plus4=0, halted=0, fetch_count=0.
REQ-029 Reset SHALL override all other inputs, including mid-stall, mid-redirect and HALTED.
REQ-030 No state SHALL change asynchronously to clk.

Verification
REQ-031 Reset release, imem returns 32'h3F00_0218 at 0x0, 32'h3B00_0018 at 0x4, no stall -> BOOT 1 cycle, then instruction=32'h3F00_0218/pc_out=0x0/pc_plus4=0x4, next cycle 32'h3B00_0018/pc_out=0x4, fetch_count=2.
REQ-032 stall=1 for 3 cycles after pc_out=0x4 -> outputs and imem_addr=0x8 unchanged for 3 cycles, fetch_count unchanged; resume captures 0x8.
REQ-033 redirect_en=1, redirect_pc=32'h0000_0103 with stall=1 -> next cycle inst_valid=0, imem_addr=0x100; following cycle pc_out=0x100, inst_valid=1.
REQ-034 halt=1 at imem_addr=0x10 -> 0x10 captured, then halted=1, inst_valid=0, imem_addr stays 0x14; redirect_pc=0x40 -> RUN, fetch at 0x40.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 reset_n=0 asserted while HALTED with fetch_count=5 -> all outputs per REQ-028, BOOT then RUN from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-cycle registered capture of imem data, BOOT/RUN/HALTED control.
// Latency 1 cycle (imem_addr in cycle N -> instruction in N+1); stall holds all outputs, redirect overrides stall/halt.
module fetch_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] pc_plus4,
    output logic                 halted,
    output logic [15:0]          fetch_count
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [WORD_SIZE-1:0] pc_out_q, pc_out_d;
    logic [WORD_SIZE-1:0] pc_plus4_q, pc_plus4_d;
    logic                 vld_q, vld_d;
    logic [15:0]          cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT:   state_d = ST_RUN;
                ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_BOOT;
            endcase
        end
    end

    // Datapath next-state; redirect wins over everything, and only RUN without stall captures.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        vld_d      = vld_q;
        cnt_d      = cnt_q;
        halted     = (state_q == ST_HALTED);
        if (redirect_en) begin
            pc_d    = redirect_pc & ~WORD_SIZE'(3);
            instr_d = '0;
            vld_d   = 1'b0;
        end else if (state_q == ST_RUN && !stall) begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + WORD_SIZE'(4);
            vld_d      = 1'b1;
            pc_d       = pc_q + WORD_SIZE'(4);
            cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end else if (state_q == ST_HALTED) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            pc_plus4_q <= '0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign inst_valid  = vld_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control, checked by a queue-based scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n, stall, redirect_en, halt;
    logic [31:0] redirect_pc;

    logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_pc4;
    logic        a_vld, a_halted;
    logic [15:0] a_cnt;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4;
    logic        b_vld, b_halted;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h3F00_0218;
        if (a == 32'h4) return 32'h3B00_0018;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign a_rdata = mem_word(a_addr);
    assign b_rdata = mem_word(b_addr);

    fetch_stage #(.WORD_SIZE(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halt(halt), .imem_addr(a_addr), .imem_rdata(a_rdata),
        .instruction(a_instr), .inst_valid(a_vld), .pc_out(a_pc), .pc_plus4(a_pc4),
        .halted(a_halted), .fetch_count(a_cnt));

    fetch_stage #(.WORD_SIZE(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halt(halt), .imem_addr(b_addr), .imem_rdata(b_rdata),
        .instruction(b_instr), .inst_valid(b_vld), .pc_out(b_pc), .pc_plus4(b_pc4),
        .halted(b_halted), .fetch_count(b_cnt));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes 0=boot, 1=running, 2=halted; expectations follow the fetch rules directly.
    int          m_mode = 0;
    logic [31:0] m_pc   = 32'h0;
    int          m_cnt  = 0;

    task automatic cyc(input logic rn, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic hl);
        exp_t e;
        @(negedge clk);
        reset_n = rn; stall = st; redirect_en = rd; redirect_pc = rpc; halt = hl;
        if (!rn) begin
            m_mode = 0; m_pc = 32'h0; m_cnt = 0;
        end else if (rd) begin
            m_mode = 1; m_pc = {rpc[31:2], 2'b00};
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!st) begin
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                e.pc   = m_pc;
                e.instr = mem_word(m_pc);
                e.pc4  = m_pc + 32'd4;
                e.cnt  = 16'(m_cnt);
                q.push_back(e);
                m_pc   = m_pc + 32'd4;
            end
            if (hl) m_mode = 2;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a change of fetch_count with inst_valid marks a newly presented instruction.
    logic        mon_en   = 1'b0;
    logic [15:0] last_cnt = 16'h0;
    logic        have_last = 1'b0;
    exp_t        last_item;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_cnt != last_cnt) begin
                last_cnt = a_cnt;
                if (a_vld) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got pc %08h with no expected entry", a_pc);
                    end else begin
                        last_item = q.pop_front();
                        have_last = 1'b1;
                        check("sb_pc",    a_pc,          last_item.pc);
                        check("sb_instr", a_instr,       last_item.instr);
                        check("sb_pc4",   a_pc4,         last_item.pc4);
                        check("sb_cnt",   32'(a_cnt),    32'(last_item.cnt));
                    end
                end
            end else if (a_vld && have_last) begin
                check("sb_hold_instr", a_instr, last_item.instr);
                check("sb_hold_pc",    a_pc,    last_item.pc);
            end
        end
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; halt = 1'b0; redirect_pc = 32'h0;

        cyc(0, 0, 0, 0, 0);
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("rst_vld",    32'(a_vld), 0);
        check("rst_pc",     a_pc, 0);
        check("rst_pc4",    a_pc4, 0);
        check("rst_instr",  a_instr, 0);
        check("rst_cnt",    32'(a_cnt), 0);
        check("rst_halted", 32'(a_halted), 0);
        check("rst_addr",   a_addr, 32'h0);
        check("rst_addr_b", b_addr, 32'hFFFF_FFF8);

        cyc(1, 0, 0, 0, 0);
        check("boot_vld",  32'(a_vld), 0);
        check("boot_addr", a_addr, 32'h0);

        cyc(1, 0, 0, 0, 0);
        check("f0_instr", a_instr, 32'h3F00_0218);
        check("f0_pc",    a_pc, 32'h0);
        check("f0_pc4",   a_pc4, 32'h4);
        check("f0_vld",   32'(a_vld), 1);
        check("b_pc0",    b_pc, 32'hFFFF_FFF8);
        cyc(1, 0, 0, 0, 0);
        check("f1_instr", a_instr, 32'h3B00_0018);
        check("f1_pc",    a_pc, 32'h4);
        check("f1_cnt",   32'(a_cnt), 2);
        check("b_pc1",    b_pc, 32'hFFFF_FFFC);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0);
            check("stall_pc",    a_pc, 32'h4);
            check("stall_instr", a_instr, 32'h3B00_0018);
            check("stall_addr",  a_addr, 32'h8);
            check("stall_cnt",   32'(a_cnt), 2);
        end
        cyc(1, 0, 0, 0, 0);
        check("resume_pc",    a_pc, 32'h8);
        check("resume_instr", a_instr, mem_word(32'h8));
        check("resume_cnt",   32'(a_cnt), 3);
        check("b_wrap",       b_pc, 32'h0);

        cyc(1, 1, 1, 32'h0000_0103, 0);
        check("redir_vld",   32'(a_vld), 0);
        check("redir_addr",  a_addr, 32'h100);
        check("redir_instr", a_instr, 0);
        cyc(1, 0, 0, 0, 0);
        check("redir_pc",  a_pc, 32'h100);
        check("redir_vld1", 32'(a_vld), 1);
        check("redir_cnt", 32'(a_cnt), 4);

        cyc(1, 0, 1, 32'h10, 0);
        check("to10_addr", a_addr, 32'h10);
        cyc(1, 0, 0, 0, 1);
        check("halt_pc",     a_pc, 32'h10);
        check("halt_halted", 32'(a_halted), 1);
        check("halt_addr",   a_addr, 32'h14);
        check("halt_cnt",    32'(a_cnt), 5);
        cyc(1, 0, 0, 0, 0);
        check("halted_vld",  32'(a_vld), 0);
        check("halted_hold", 32'(a_halted), 1);
        check("halted_addr", a_addr, 32'h14);
        check("halted_cnt",  32'(a_cnt), 5);

        cyc(0, 1, 0, 0, 1);
        check("hrst_vld",    32'(a_vld), 0);
        check("hrst_pc",     a_pc, 0);
        check("hrst_cnt",    32'(a_cnt), 0);
        check("hrst_halted", 32'(a_halted), 0);
        check("hrst_addr",   a_addr, 32'h0);
        cyc(1, 0, 0, 0, 0);
        check("hrst_boot", 32'(a_vld), 0);
        cyc(1, 0, 0, 0, 0);
        check("hrst_run_pc", a_pc, 32'h0);
        check("hrst_run_vld", 32'(a_vld), 1);

        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        check("h2_halted", 32'(a_halted), 1);
        check("h2_addr",   a_addr, 32'h8);
        cyc(1, 0, 1, 32'h40, 0);
        check("exit_halted", 32'(a_halted), 0);
        check("exit_addr",   a_addr, 32'h40);
        cyc(1, 0, 0, 0, 0);
        check("exit_pc",  a_pc, 32'h40);
        check("exit_cnt", 32'(a_cnt), 3);

        for (int i = 0; i < 3000; i++) begin
            int r_st, r_rd, r_hl, r_rst;
            r_st  = $urandom_range(99);
            r_rd  = $urandom_range(99);
            r_hl  = $urandom_range(99);
            r_rst = $urandom_range(199);
            cyc((r_rst != 0), (r_st < 30), (r_rd < 5), $urandom, (r_hl < 3));
        end

        cyc(1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
